// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - truth-table self-test sequencer for a two-input gate
// Walks {a,b} through 00,01,10,11, samples the gate after a settle time, compares to a latched table.
module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] mismatch,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] exp_l, exp_n;
  logic [3:0] res_n, mm_n;
  logic [1:0] vec_n;
  logic       pass_n, done_n, busy_n, a_n, b_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      exp_l    <= 4'd0;
      result   <= 4'd0;
      mismatch <= 4'd0;
      vec_idx  <= 2'd0;
      pass     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      exp_l    <= exp_n;
      result   <= res_n;
      mismatch <= mm_n;
      vec_idx  <= vec_n;
      pass     <= pass_n;
      done     <= done_n;
      busy     <= busy_n;
      dut_a    <= a_n;
      dut_b    <= b_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exp_n   = exp_l;
    res_n   = result;
    mm_n    = mismatch;
    vec_n   = vec_idx;
    pass_n  = pass;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        vec_n = 2'd0;
        if (start && !abort) begin
          state_n = RUN;
          exp_n   = expected;
          res_n   = 4'd0;
          mm_n    = 4'd0;
          pass_n  = 1'b0;
          cnt_n   = RELOAD;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          res_n   = 4'd0;
          mm_n    = 4'd0;
          pass_n  = 1'b0;
          vec_n   = 2'd0;
          cnt_n   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          res_n[vec_idx] = dut_y;
          mm_n[vec_idx]  = dut_y ^ exp_l[vec_idx];
          if (vec_idx != 2'd3) begin
            vec_n = vec_idx + 2'd1;
            cnt_n = RELOAD;
          end else begin
            // pass must see the final sample, so it is derived from the updated mask
            state_n = DONE;
            done_n  = 1'b1;
            pass_n  = ~|mm_n;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        vec_n   = 2'd0;
      end
      default: begin
        state_n = IDLE;
        vec_n   = 2'd0;
      end
    endcase

    // Gate inputs are registered from the next vector so they change on the sampling edge
    busy_n = (state_n == RUN);
    a_n    = busy_n & vec_n[1];
    b_n    = busy_n & vec_n[0];
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - scoreboard bench for gate_tt_checker driving a NOR gate model
// Instance 0 uses SETTLE_CYCLES=2, instance 1 uses SETTLE_CYCLES=1.
module tb_gate_tt_checker;

  typedef struct {
    logic [3:0] res;
    logic [3:0] mm;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [2];
  logic       abort_v [2];
  logic [3:0] exp_v   [2];
  logic       a_v     [2];
  logic       b_v     [2];
  logic       y_v     [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       pass_v  [2];
  logic [3:0] res_v   [2];
  logic [3:0] mm_v    [2];
  logic [1:0] vec_v   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  assign y_v[0] = ~(a_v[0] | b_v[0]);
  assign y_v[1] = ~(a_v[1] | b_v[1]);

  gate_tt_checker #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .expected(exp_v[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .result(res_v[0]), .mismatch(mm_v[0]), .vec_idx(vec_v[0])
  );

  gate_tt_checker #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .expected(exp_v[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .result(res_v[1]), .mismatch(mm_v[1]), .vec_idx(vec_v[1])
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_done(input int u);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      n_total++;
      $display("FAIL unexpected_done: inst %0d got done=1, expected no done at %0t", u, $time);
      return;
    end
    if (u == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("sb_result%0d", u), 8'(res_v[u]), 8'(e.res));
    chk($sformatf("sb_mismatch%0d", u), 8'(mm_v[u]), 8'(e.mm));
    chk($sformatf("sb_pass%0d", u), 8'(pass_v[u]), 8'(e.p));
  endtask

  always @(posedge clk) begin
    #2;
    for (int u = 0; u < 2; u++)
      if (done_v[u] === 1'b1) check_done(u);
  end

  // mode: 0 normal, 1 abort at window kev, 2 reset at window kev, 3 start pulses while busy,
  // 4 expected changed at window kev
  task automatic run(input int u, input int s, input logic [3:0] ex, input logic [3:0] e_res,
                     input logic [3:0] e_mm, input logic e_pass, input int mode, input int kev);
    exp_t e;
    exp_v[u]   = ex;
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    e.res = e_res; e.mm = e_mm; e.p = e_pass;
    if (mode == 0 || mode == 3 || mode == 4) begin
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    chk("start_clears_result", 8'(res_v[u]), 8'd0);
    chk("start_clears_pass", 8'(pass_v[u]), 8'd0);
    for (int k = 0; k < 4 * s; k++) begin
      chk("busy_run", 8'(busy_v[u]), 8'd1);
      chk("vec_idx", 8'(vec_v[u]), 8'(k / s));
      chk("dut_ab", 8'({a_v[u], b_v[u]}), 8'(k / s));
      chk("no_early_done", 8'(done_v[u]), 8'd0);
      if (mode == 1 && k == kev) begin
        abort_v[u] = 1'b1;
        tick();
        abort_v[u] = 1'b0;
        chk("abort_busy", 8'(busy_v[u]), 8'd0);
        chk("abort_ab", 8'({a_v[u], b_v[u]}), 8'd0);
        chk("abort_result", 8'(res_v[u]), 8'd0);
        chk("abort_mismatch", 8'(mm_v[u]), 8'd0);
        chk("abort_pass", 8'(pass_v[u]), 8'd0);
        chk("abort_done", 8'(done_v[u]), 8'd0);
        repeat (4 * s + 2) tick();
        return;
      end
      if (mode == 2 && k == kev) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 8'(busy_v[u]), 8'd0);
        chk("rst_done", 8'(done_v[u]), 8'd0);
        chk("rst_pass", 8'(pass_v[u]), 8'd0);
        chk("rst_result", 8'(res_v[u]), 8'd0);
        chk("rst_mismatch", 8'(mm_v[u]), 8'd0);
        chk("rst_vec", 8'(vec_v[u]), 8'd0);
        chk("rst_ab", 8'({a_v[u], b_v[u]}), 8'd0);
        repeat (4 * s + 2) tick();
        return;
      end
      if (mode == 3) start_v[u] = (k == 1 || k == 3);
      if (mode == 4 && k == kev) exp_v[u] = 4'b1111;
      tick();
    end
    chk("done_pulse", 8'(done_v[u]), 8'd1);
    chk("done_busy", 8'(busy_v[u]), 8'd0);
    if (mode == 3) start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    chk("done_one_cycle", 8'(done_v[u]), 8'd0);
    chk("idle_after_done", 8'(busy_v[u]), 8'd0);
    chk("pass_hold", 8'(pass_v[u]), 8'(e_pass));
    chk("result_hold", 8'(res_v[u]), 8'(e_res));
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0;
      abort_v[u] = 1'b0;
      exp_v[u]   = 4'b0000;
    end
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("reset_busy", 8'(busy_v[u]), 8'd0);
      chk("reset_done", 8'(done_v[u]), 8'd0);
      chk("reset_pass", 8'(pass_v[u]), 8'd0);
      chk("reset_result", 8'(res_v[u]), 8'd0);
      chk("reset_mismatch", 8'(mm_v[u]), 8'd0);
      chk("reset_vec", 8'(vec_v[u]), 8'd0);
      chk("reset_ab", 8'({a_v[u], b_v[u]}), 8'd0);
    end
    rst = 1'b0;
    tick();

    run(0, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1, 0, 0);
    run(0, 2, 4'b0111, 4'b0001, 4'b0110, 1'b0, 0, 0);
    run(0, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1, 4);

    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("start_abort_idle", 8'(busy_v[0]), 8'd0);
    tick();

    run(0, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1, 3, 0);
    run(0, 2, 4'b1110, 4'b0001, 4'b1111, 1'b0, 0, 0);
    run(0, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2, 2);
    run(0, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1, 0, 0);
    run(1, 1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4, 1);

    repeat (4) tick();
    chk("sb_drained0", 8'(q0.size()), 8'd0);
    chk("sb_drained1", 8'(q1.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
